rf16_inq_reader: RTL and testbench
==================================

Name: rf16_inq_reader

Overview:
Read-side drain engine for the 16-entry x 2-bit inbound queue register array.
- The write side fills array entries in address order and pulses `push` once per entry written.
- This block tracks occupancy, walks a wrapping read pointer, captures the addressed entry, and presents it on a valid/ready output port.
- It sits between the queue array and the downstream consumer of queue entries.

Parameters:
- DEPTH, 16, number of array entries (power of two).
- ENTRY_W, 2, bits per entry.
- ADDR_W, 4, read-pointer width (log2 DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_l  input  1  asynchronous active-low reset.
- rd_en  input  1  enable; when low, no new fetch is started.
- push  input  1  one-cycle pulse per entry written by the write side.
- inq_ary  input  DEPTH*ENTRY_W  flattened array; entry i occupies bits [i*ENTRY_W +: ENTRY_W].
- rd_valid  output  1  rd_data holds a valid entry.
- rd_ready  input  1  consumer accepts rd_data.
- rd_data  output  ENTRY_W  captured entry.
- rd_addr  output  ADDR_W  array address of the entry on rd_data.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push arrived while full.

Behaviour:
- Reset (reset_l low, asynchronous, takes effect mid-operation):
  - state=IDLE, rd_ptr=0, count=0, rd_data=0, rd_addr=0.
  - rd_valid=0, overflow=0, empty=1, full=0.
  - Any in-flight entry is discarded.
- States: IDLE, LOAD, HOLD.
  - IDLE: rd_valid=0. If rd_en && count!=0, go to LOAD next cycle.
  - LOAD: capture inq_ary[rd_ptr] into rd_data and rd_ptr into rd_addr; go to HOLD. rd_valid=0 during LOAD.
  - HOLD: rd_valid=1.
    - On rd_valid&&rd_ready (pop): rd_ptr increments, wrapping 15->0, and count decrements.
    - After a pop, go to LOAD if rd_en && (count-1+push)!=0; otherwise go to IDLE.
- Latency and throughput:
  - First push into an empty queue with rd_en=1: count=1 at edge N+1, LOAD at N+1, rd_valid=1 from edge N+2.
  - Sustained throughput is one pop per 2 cycles when rd_ready is held high.
- Handshake rules:
  - rd_data and rd_addr stay stable while rd_valid && !rd_ready.
  - rd_valid never drops without a pop, even if rd_en falls during HOLD.
  - rd_en low only blocks the IDLE->LOAD and HOLD->LOAD transitions.
- Occupancy:
  - count next = count + push - pop.
  - Simultaneous push and pop leave count unchanged.
  - push while count==DEPTH with no pop: count stays DEPTH and overflow sets.
  - overflow clears only on reset.
  - Pop cannot occur while count==0; the state machine guarantees this.
- empty and full are combinational from count.

Optional Feature:
RF_INQ_PARITY_EN
- Defined:
  - Adds output port rd_parity (1 bit), registered in LOAD as the XOR of the captured entry bits.
  - Reset value 0.
  - Held stable with rd_data.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, rd_en=1, write entry0=2'b10, pulse push at cycle 5 -> count=1 at cycle 6, rd_valid=1 at cycle 7 with rd_data=2'b10, rd_addr=0. rd_ready=1 -> count=0, empty=1, state IDLE.
2. Fill all 16 entries with value i[1:0], rd_en=0, then one extra push -> count=16, full=1, overflow=1. Set rd_en=1, rd_ready=1 -> 16 pops in order, rd_addr 0..15, rd_data = addr[1:0], then empty=1.
3. Wrap-around: after test 2, push 3 more (entries 0..2) -> next rd_addr sequence is 0,1,2 and rd_ptr wraps correctly.
4. Back-pressure: rd_valid=1 with rd_ready=0 for 5 cycles, then toggle rd_en low -> rd_data and rd_addr unchanged, rd_valid stays 1. rd_ready=1 -> single pop, count decrements by 1.
5. Simultaneous push and pop at count=4 -> count stays 4. Assert reset_l low during HOLD -> rd_valid=0, count=0, overflow=0 immediately, without waiting for a clock edge.
6. With RF_INQ_PARITY_EN defined: entry 2'b01 -> rd_parity=1; entry 2'b11 -> rd_parity=0.

Source files
------------

// File: rtl/rf16_inq_reader_if.sv
// Read-port bundle of the inbound queue drain engine: valid/ready entry output.
// With RF_INQ_PARITY_EN defined, the bundle also carries rd_parity.
interface rf16_inq_reader_if #(
    parameter int ENTRY_W = 2,
    parameter int ADDR_W  = 4
);
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;
    logic [ADDR_W-1:0]  rd_addr;
`ifdef RF_INQ_PARITY_EN
    logic               rd_parity;
`endif

    modport master (
        input  rd_ready,
        output rd_valid,
        output rd_data,
        output rd_addr
`ifdef RF_INQ_PARITY_EN
        , output rd_parity
`endif
    );

    modport slave (
        output rd_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_addr
`ifdef RF_INQ_PARITY_EN
        , input  rd_parity
`endif
    );
endinterface

// File: rtl/rf16_inq_reader.sv
// Read-side drain engine for the 16 x 2-bit inbound queue array: occupancy, wrapping read
// pointer, entry capture and valid/ready presentation. Optional RF_INQ_PARITY_EN adds rd_parity.
module rf16_inq_reader #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 2,
    parameter int ADDR_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic                     rd_en,
    input  logic                     push,
    input  logic [DEPTH*ENTRY_W-1:0] inq_ary,
    rf16_inq_reader_if.master        rd_if,
    output logic [ADDR_W:0]          count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t             state;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               valid_q;
    logic [ENTRY_W-1:0] data_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               pop;
    logic               ovf_set;
    logic [ADDR_W:0]    count_nxt;
    logic [ENTRY_W-1:0] entry_sel;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign entry_sel = inq_ary[int'(rd_ptr)*ENTRY_W +: ENTRY_W];

    assign rd_if.rd_valid = valid_q;
    assign rd_if.rd_data  = data_q;
    assign rd_if.rd_addr  = addr_q;

    always_comb begin
        pop       = (state == HOLD) && rd_if.rd_ready;
        ovf_set   = 1'b0;
        count_nxt = count;
        if (push && !pop) begin
            if (full) ovf_set = 1'b1;
            else      count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Fetch decisions look at next occupancy so a push arriving this cycle starts a LOAD at once.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            count    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (ovf_set) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (rd_en && (count_nxt != '0)) state <= LOAD;
                end
                LOAD: begin
                    data_q  <= entry_sel;
                    addr_q  <= rd_ptr;
                    valid_q <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (pop) begin
                        valid_q <= 1'b0;
                        rd_ptr  <= rd_ptr + 1'b1;
                        state   <= (rd_en && (count_nxt != '0)) ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RF_INQ_PARITY_EN
    logic parity_q;

    assign rd_if.rd_parity = parity_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)           parity_q <= 1'b0;
        else if (state == LOAD) parity_q <= ^entry_sel;
    end
`endif

endmodule

// File: tb/tb_rf16_inq_reader.sv
// Scoreboard bench for rf16_inq_reader: stimulus queues expected {addr,data}, a monitor checks pops.
// Build with RF_INQ_PARITY_EN defined to also check rd_parity.
module tb_rf16_inq_reader;

    logic        clk;
    logic        reset_l;
    logic        rd_en;
    logic        push;
    logic [31:0] ary;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    int          errors;
    int          checks;
    logic [3:0]  wp;
    logic [5:0]  sb_q[$];

    rf16_inq_reader_if #(.ENTRY_W(2), .ADDR_W(4)) rif ();

    rf16_inq_reader #(.DEPTH(16), .ENTRY_W(2), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .rd_en    (rd_en),
        .push     (push),
        .inq_ary  (ary),
        .rd_if    (rif.master),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted entry against the scoreboard, and check hold stability.
    logic       prev_hold;
    logic [1:0] prev_data;
    logic [3:0] prev_addr;
    logic [5:0] exp_e;
    initial prev_hold = 1'b0;
    always @(negedge clk) begin
        if (!reset_l) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(rif.rd_valid), 32'd1);
                chk("hold_data", 32'(rif.rd_data), 32'(prev_data));
                chk("hold_addr", 32'(rif.rd_addr), 32'(prev_addr));
            end
            if (rif.rd_valid && rif.rd_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    exp_e = sb_q.pop_front();
                    chk("pop_addr", 32'(rif.rd_addr), 32'(exp_e[5:2]));
                    chk("pop_data", 32'(rif.rd_data), 32'(exp_e[1:0]));
`ifdef RF_INQ_PARITY_EN
                    chk("pop_parity", 32'(rif.rd_parity), 32'(^exp_e[1:0]));
`endif
                end
            end
            prev_hold = rif.rd_valid && !rif.rd_ready;
            prev_data = rif.rd_data;
            prev_addr = rif.rd_addr;
        end
    end

    task automatic push_entry(input logic [1:0] v);
        ary[int'(wp)*2 +: 2] = v;
        push = 1'b1;
        sb_q.push_back({wp, v});
        @(posedge clk); #1;
        push = 1'b0;
        wp = wp + 4'd1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        push    = 1'b0;
        sb_q.delete();
        wp  = '0;
        ary = '0;
        #1;
        chk("rst_valid", 32'(rif.rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_data", 32'(rif.rd_data), 32'd0);
        chk("rst_addr", 32'(rif.rd_addr), 32'd0);
`ifdef RF_INQ_PARITY_EN
        chk("rst_parity", 32'(rif.rd_parity), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!rif.rd_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(rif.rd_valid), 32'd1);
    endtask

    task automatic wait_drained(input string nm);
        int n;
        n = 0;
        while ((count != 0 || rif.rd_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(count), 32'd0);
        chk({nm, "_sb"}, 32'(sb_q.size()), 32'd0);
    endtask

    logic [1:0] hd;
    logic [3:0] ha;

    initial begin
        errors = 0;
        checks = 0;
        rd_en  = 1'b1;
        rif.rd_ready = 1'b1;
        push   = 1'b0;
        wp     = '0;
        ary    = '0;

        // Single entry: latency and drain.
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        push_entry(2'b10);
        chk("t1_count_after_push", 32'(count), 32'd1);
        chk("t1_valid_in_load", 32'(rif.rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid", 32'(rif.rd_valid), 32'd1);
        chk("t1_data", 32'(rif.rd_data), 32'd2);
        chk("t1_addr", 32'(rif.rd_addr), 32'd0);
        @(posedge clk); #1;
        chk("t1_count_after_pop", 32'(count), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_valid_after_pop", 32'(rif.rd_valid), 32'd0);

        // Fill to full with rd_en low, overflow, then drain in order.
        do_reset();
        rd_en = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push_entry(2'(i));
        chk("t2_count_full", 32'(count), 32'd16);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_no_overflow_yet", 32'(overflow), 32'd0);
        chk("t2_idle_valid", 32'(rif.rd_valid), 32'd0);
        push = 1'b1;
        @(posedge clk); #1;
        push = 1'b0;
        chk("t2_count_sat", 32'(count), 32'd16);
        chk("t2_overflow", 32'(overflow), 32'd1);
        rd_en = 1'b1;
        wait_drained("t2_drain");
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_overflow_sticky", 32'(overflow), 32'd1);

        // Wrap-around: pointer continues at 0.
        push_entry(2'b11);
        push_entry(2'b01);
        push_entry(2'b10);
        wait_drained("t3_drain");

        // Back-pressure and rd_en dropping during HOLD.
        rif.rd_ready = 1'b0;
        push_entry(2'b01);
        push_entry(2'b11);
        wait_valid("t4_valid");
        hd = rif.rd_data;
        ha = rif.rd_addr;
        chk("t4_addr", 32'(ha), 32'd3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t4_valid_held", 32'(rif.rd_valid), 32'd1);
        chk("t4_data_held", 32'(rif.rd_data), 32'(hd));
        chk("t4_addr_held", 32'(rif.rd_addr), 32'(ha));
        chk("t4_count_before", 32'(count), 32'd2);
        rif.rd_ready = 1'b1;
        @(posedge clk); #1;
        rif.rd_ready = 1'b0;
        chk("t4_count_after", 32'(count), 32'd1);
        chk("t4_valid_after", 32'(rif.rd_valid), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t4_blocked", 32'(rif.rd_valid), 32'd0);
        rd_en = 1'b1;
        rif.rd_ready = 1'b1;
        wait_drained("t4_drain");

        // Simultaneous push/pop at count 4, then asynchronous reset during HOLD.
        rd_en = 1'b0;
        rif.rd_ready = 1'b0;
        push_entry(2'b01);
        push_entry(2'b11);
        push_entry(2'b10);
        push_entry(2'b01);
        chk("t5_count4", 32'(count), 32'd4);
        rd_en = 1'b1;
        wait_valid("t5_valid");
        rif.rd_ready = 1'b1;
        push_entry(2'b11);
        rif.rd_ready = 1'b0;
        chk("t5_count_pushpop", 32'(count), 32'd4);
        wait_valid("t5_valid2");
        #3;
        reset_l = 1'b0;
        sb_q.delete();
        #1;
        chk("t5_async_valid", 32'(rif.rd_valid), 32'd0);
        chk("t5_async_count", 32'(count), 32'd0);
        chk("t5_async_overflow", 32'(overflow), 32'd0);
        chk("t5_async_empty", 32'(empty), 32'd1);
        @(posedge clk); #1;
        wp  = '0;
        ary = '0;
        reset_l = 1'b1;

        // Parity-relevant entries 01 and 11.
        rif.rd_ready = 1'b1;
        push_entry(2'b01);
        push_entry(2'b11);
        wait_drained("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
